// File: rtl/dm_responder.sv
// dm_responder: wait-state data memory behind a request/response handshake.
// A load/store is captured in IDLE, held for LATENCY+1 BUSY cycles, then
// completed with a one-cycle resp_valid pulse in RESP. While the access is
// outstanding, stall tells the pipeline to freeze.
module dm_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_BITS   = 8,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        stall,
    output logic [15:0] access_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] LAT = 4'(LATENCY);

    state_t         state;
    logic [3:0]     cnt;
    logic [31:0]    cap_addr;
    logic [31:0]    cap_wdata;
    logic           cap_write;

    logic [31:0]    mem [DEPTH_WORDS];

    logic                 addr_err;
    logic [ADDR_BITS-1:0] idx;
    logic                 fire;

    // Decode the captured address and detect the cycle in which the access completes.
    always_comb begin
        addr_err = (cap_addr[1:0] != 2'b00) ||
                   (cap_addr[31:ADDR_BITS+2] != {(30-ADDR_BITS){1'b0}});
        idx      = cap_addr[ADDR_BITS+1:2];
        fire     = (state == BUSY) && (cnt == 4'd0);
    end

    // Stall follows the request combinationally in IDLE so the pipeline freezes in the accept cycle.
    assign stall = ((state == IDLE) && req_valid) || (state == BUSY);

    // Memory array: written only on a clean store completion; never reset, so contents persist.
    always_ff @(posedge clk) begin
        if (fire && cap_write && !addr_err) begin
            mem[idx] <= cap_wdata;
        end
    end

    // Handshake FSM with registered ready/response outputs and completion counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            cap_addr     <= 32'd0;
            cap_wdata    <= 32'd0;
            cap_write    <= 1'b0;
            req_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            resp_rdata   <= 32'd0;
            resp_err     <= 1'b0;
            access_count <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cap_addr  <= req_addr;
                        cap_wdata <= req_wdata;
                        cap_write <= req_write;
                        cnt       <= LAT;
                        req_ready <= 1'b0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        // Stores and faulting accesses return zero data.
                        resp_rdata   <= (addr_err || cap_write) ? 32'd0 : mem[idx];
                        resp_err     <= addr_err;
                        resp_valid   <= 1'b1;
                        access_count <= access_count + 16'd1;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    // Any request seen here is ignored; it is taken up again in IDLE.
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: one instance at LATENCY=2, one at LATENCY=0.
// Expected responses come from a small memory model and are queued at issue time.
module tb_dm_responder;

    logic        clk;
    logic        rst;
    logic        req_valid    [2];
    logic        req_write    [2];
    logic [31:0] req_addr     [2];
    logic [31:0] req_wdata    [2];
    logic        req_ready    [2];
    logic        resp_valid   [2];
    logic [31:0] resp_rdata   [2];
    logic        resp_err     [2];
    logic        stall        [2];
    logic [15:0] access_count [2];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sbq [$];
    logic [31:0] model [2][256];
    logic [15:0] acc_model [2];
    int          checks;
    int          failures;

    dm_responder #(.DEPTH_WORDS(256), .ADDR_BITS(8), .LATENCY(2)) u_lat2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .req_ready(req_ready[0]), .resp_valid(resp_valid[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
        .stall(stall[0]), .access_count(access_count[0])
    );

    dm_responder #(.DEPTH_WORDS(256), .ADDR_BITS(8), .LATENCY(0)) u_lat0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .req_ready(req_ready[1]), .resp_valid(resp_valid[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
        .stall(stall[1]), .access_count(access_count[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One complete access on instance k; request inputs are scrambled after acceptance.
    task automatic access(input int k, input int lat, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wd);
        exp_t e;
        logic err;
        int   idx;
        int   n;
        bit   got;
        err = (addr[1:0] != 2'b00) || (addr[31:10] != 22'd0);
        idx = int'(addr[9:2]);
        e.err   = err;
        e.rdata = 32'd0;
        if (!err && !wr) e.rdata = model[k][idx];
        if (!err && wr)  model[k][idx] = wd;
        sbq.push_back(e);

        @(negedge clk);
        req_valid[k] = 1'b1;
        req_write[k] = wr;
        req_addr[k]  = addr;
        req_wdata[k] = wd;
        #1;
        check1("ready_idle", req_ready[k], 1'b1);
        check1("stall_accept", stall[k], 1'b1);
        @(negedge clk);
        req_valid[k] = 1'b0;
        req_write[k] = ~wr;
        req_addr[k]  = 32'hFFFF_FFFF;
        req_wdata[k] = 32'h5A5A_5A5A;
        n   = 1;
        got = 1'b0;
        while (!got && n <= lat + 6) begin
            if (resp_valid[k]) begin
                got = 1'b1;
            end else begin
                check1("stall_busy", stall[k], 1'b1);
                check1("ready_busy", req_ready[k], 1'b0);
                @(negedge clk);
                n++;
            end
        end
        check("latency", got ? 32'(n) : 32'hFFFF_FFFF, 32'(lat + 2));
        e = sbq.pop_front();
        if (got) begin
            acc_model[k] = acc_model[k] + 16'd1;
            check("rdata", resp_rdata[k], e.rdata);
            check1("err", resp_err[k], e.err);
            check1("stall_resp", stall[k], 1'b0);
            check1("ready_resp", req_ready[k], 1'b0);
            check("access_count", 32'(access_count[k]), 32'(acc_model[k]));
            @(negedge clk);
            check1("resp_pulse", resp_valid[k], 1'b0);
            check("rdata_hold", resp_rdata[k], e.rdata);
        end
    endtask

    initial begin
        exp_t e;
        int   nresp;
        int   last;
        int   cyc;
        checks    = 0;
        failures  = 0;
        acc_model[0] = 16'd0;
        acc_model[1] = 16'd0;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 1'b0;
            req_write[k] = 1'b0;
            req_addr[k]  = 32'd0;
            req_wdata[k] = 32'd0;
        end
        rst = 1'b1;
        #3;
        check1("rst_ready", req_ready[0], 1'b1);
        check1("rst_resp_valid", resp_valid[0], 1'b0);
        check("rst_rdata", resp_rdata[0], 32'd0);
        check1("rst_err", resp_err[0], 1'b0);
        check("rst_count", 32'(access_count[0]), 32'd0);
        check1("rst_stall", stall[0], 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Store then load, misaligned and out-of-range accesses at LATENCY=2.
        access(0, 2, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        access(0, 2, 1'b0, 32'h0000_0010, 32'd0);
        access(0, 2, 1'b1, 32'h0000_0013, 32'h0000_1234);
        access(0, 2, 1'b0, 32'h0000_0010, 32'd0);
        access(0, 2, 1'b1, 32'h0000_03FC, 32'h0BAD_F00D);
        access(0, 2, 1'b0, 32'h0000_0400, 32'd0);
        access(0, 2, 1'b0, 32'h0000_03FC, 32'd0);
        access(0, 2, 1'b1, 32'h0000_0020, 32'h0000_5555);
        access(0, 2, 1'b0, 32'h0000_0020, 32'd0);

        // LATENCY=0: seed memory, then back-to-back loads with req_valid held.
        access(1, 0, 1'b1, 32'h0000_0000, 32'h1111_1111);
        access(1, 0, 1'b1, 32'h0000_0004, 32'h2222_2222);
        access(1, 0, 1'b1, 32'h0000_0008, 32'h3333_3333);
        for (int i = 0; i < 3; i++) begin
            e.rdata = model[1][i];
            e.err   = 1'b0;
            sbq.push_back(e);
        end
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_write[1] = 1'b0;
        req_addr[1]  = 32'h0000_0000;
        nresp = 0;
        last  = -1;
        cyc   = 0;
        while (nresp < 3 && cyc < 40) begin
            #1;
            check1("b2b_stall", stall[1], ~resp_valid[1]);
            if (resp_valid[1]) begin
                e = sbq.pop_front();
                check("b2b_rdata", resp_rdata[1], e.rdata);
                check1("b2b_err", resp_err[1], 1'b0);
                if (last >= 0) check("b2b_period", 32'(cyc - last), 32'd3);
                last  = cyc;
                nresp = nresp + 1;
                acc_model[1] = acc_model[1] + 16'd1;
                req_addr[1]  = 32'(nresp * 4);
            end
            @(negedge clk);
            cyc++;
        end
        req_valid[1] = 1'b0;
        check("b2b_responses", 32'(nresp), 32'd3);
        check("b2b_count", 32'(access_count[1]), 32'(acc_model[1]));

        // Reset while a store is in BUSY: dropped, no response, counter cleared.
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_addr[0]  = 32'h0000_0020;
        req_wdata[0] = 32'h0000_CAFE;
        @(negedge clk);
        req_valid[0] = 1'b0;
        #1;
        check1("mid_busy_stall", stall[0], 1'b1);
        #1;
        rst = 1'b1;
        #1;
        check1("mid_rst_ready", req_ready[0], 1'b1);
        check1("mid_rst_resp_valid", resp_valid[0], 1'b0);
        check("mid_rst_rdata", resp_rdata[0], 32'd0);
        check1("mid_rst_err", resp_err[0], 1'b0);
        check("mid_rst_count", 32'(access_count[0]), 32'd0);
        check1("mid_rst_stall", stall[0], 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        acc_model[0] = 16'd0;
        acc_model[1] = 16'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check1("no_resp_after_rst", resp_valid[0], 1'b0);
        end
        access(0, 2, 1'b0, 32'h0000_0020, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
